// File: rtl/systolic_matrix.sv
// systolic_matrix: 2x2 output-stationary systolic array, signed 8-bit operands,
// 32-bit wrapping accumulators. A ripples right, B ripples down, one PE per cycle.
module systolic_matrix (
    input  logic               clk,
    input  logic               reset,
    input  logic               push11,
    input  logic               pushedge,
    input  logic               push22,
    input  logic signed [7:0]  a1X,
    input  logic signed [7:0]  a2X,
    input  logic signed [7:0]  bX1,
    input  logic signed [7:0]  bX2,
    output logic signed [31:0] c11,
    output logic signed [31:0] c12,
    output logic signed [31:0] c21,
    output logic signed [31:0] c22
);

    localparam int unsigned OP_W   = 8;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned ACC_W  = 32;

    // Pass-through registers that have a consumer inside the array. The
    // outward-facing pass-throughs of PE12/PE21/PE22 drive nothing in a 2x2
    // array, so they are not built.
    logic signed [OP_W-1:0]   a11_q, a11_d;
    logic signed [OP_W-1:0]   b11_q, b11_d;
    logic signed [OP_W-1:0]   a21_q, a21_d;
    logic signed [OP_W-1:0]   b12_q, b12_d;

    logic signed [ACC_W-1:0]  acc11_q, acc11_d;
    logic signed [ACC_W-1:0]  acc12_q, acc12_d;
    logic signed [ACC_W-1:0]  acc21_q, acc21_d;
    logic signed [ACC_W-1:0]  acc22_q, acc22_d;

    logic signed [PROD_W-1:0] prod11_c, prod12_c, prod21_c, prod22_c;

    // Per-PE products and next-state: push loads the product, otherwise accumulate.
    always_comb begin
        a11_d    = a1X;
        b11_d    = bX1;
        a21_d    = a2X;
        b12_d    = bX2;

        prod11_c = PROD_W'(a1X)   * PROD_W'(bX1);
        prod12_c = PROD_W'(a11_q) * PROD_W'(bX2);
        prod21_c = PROD_W'(a2X)   * PROD_W'(b11_q);
        prod22_c = PROD_W'(a21_q) * PROD_W'(b12_q);

        acc11_d  = acc11_q + ACC_W'(prod11_c);
        acc12_d  = acc12_q + ACC_W'(prod12_c);
        acc21_d  = acc21_q + ACC_W'(prod21_c);
        acc22_d  = acc22_q + ACC_W'(prod22_c);

        if (push11) begin
            acc11_d = ACC_W'(prod11_c);
        end
        if (pushedge) begin
            acc12_d = ACC_W'(prod12_c);
            acc21_d = ACC_W'(prod21_c);
        end
        if (push22) begin
            acc22_d = ACC_W'(prod22_c);
        end
    end

    // State registers; reset clears operands and partial sums.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a11_q   <= '0;
            b11_q   <= '0;
            a21_q   <= '0;
            b12_q   <= '0;
            acc11_q <= '0;
            acc12_q <= '0;
            acc21_q <= '0;
            acc22_q <= '0;
        end else begin
            a11_q   <= a11_d;
            b11_q   <= b11_d;
            a21_q   <= a21_d;
            b12_q   <= b12_d;
            acc11_q <= acc11_d;
            acc12_q <= acc12_d;
            acc21_q <= acc21_d;
            acc22_q <= acc22_d;
        end
    end

    assign c11 = acc11_q;
    assign c12 = acc12_q;
    assign c21 = acc21_q;
    assign c22 = acc22_q;

endmodule

// File: tb/tb_systolic_matrix.sv
// Directed bench for systolic_matrix with hand-computed expected values.
module tb_systolic_matrix;

    logic               clk;
    logic               reset;
    logic               push11, pushedge, push22;
    logic signed [7:0]  a1X, a2X, bX1, bX2;
    logic signed [31:0] c11, c12, c21, c22;

    int tests_run;
    int tests_failed;

    systolic_matrix dut (
        .clk      (clk),
        .reset    (reset),
        .push11   (push11),
        .pushedge (pushedge),
        .push22   (push22),
        .a1X      (a1X),
        .a2X      (a2X),
        .bX1      (bX1),
        .bX2      (bX2),
        .c11      (c11),
        .c12      (c12),
        .c21      (c21),
        .c22      (c22)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, clock it in, sample 1 time unit after the edge.
    task automatic step(input int a1, input int a2, input int b1, input int b2,
                        input logic p11, input logic pe, input logic p22);
        a1X      = 8'(a1);
        a2X      = 8'(a2);
        bX1      = 8'(b1);
        bX2      = 8'(b2);
        push11   = p11;
        pushedge = pe;
        push22   = p22;
        @(posedge clk);
        #1;
    endtask

    // Skewed stream of A=[[-6,7],[1,-4]], B=[[-2,0],[9,1]]; outputs sampled at
    // each one's final-value edge (c11 E0+1, c12/c21 E0+2, c22 E0+3).
    task automatic feed_product(input logic use_push,
                                output logic signed [31:0] o11, output logic signed [31:0] o12,
                                output logic signed [31:0] o21, output logic signed [31:0] o22);
        step(-6,  0, -2, 0, use_push, 1'b0, 1'b0);
        step( 7,  1,  9, 0, 1'b0, use_push, 1'b0);
        o11 = c11;
        step( 0, -4,  0, 1, 1'b0, 1'b0, use_push);
        o12 = c12;
        o21 = c21;
        step( 0,  0,  0, 0, 1'b0, 1'b0, 1'b0);
        o22 = c22;
    endtask

    task automatic test_reset();
        a1X = '0; a2X = '0; bX1 = '0; bX2 = '0;
        push11 = 1'b0; pushedge = 1'b0; push22 = 1'b0;
        reset = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        tests_run++;
        if (c11 !== 32'sd0) begin tests_failed++; $display("FAIL reset_async_c11 got %0d want 0", c11); end
        tests_run++;
        if (c12 !== 32'sd0) begin tests_failed++; $display("FAIL reset_async_c12 got %0d want 0", c12); end
        tests_run++;
        if (c21 !== 32'sd0) begin tests_failed++; $display("FAIL reset_async_c21 got %0d want 0", c21); end
        tests_run++;
        if (c22 !== 32'sd0) begin tests_failed++; $display("FAIL reset_async_c22 got %0d want 0", c22); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (c11 !== 32'sd0) begin tests_failed++; $display("FAIL reset_idle_c11 got %0d want 0", c11); end
        tests_run++;
        if (c12 !== 32'sd0) begin tests_failed++; $display("FAIL reset_idle_c12 got %0d want 0", c12); end
        tests_run++;
        if (c21 !== 32'sd0) begin tests_failed++; $display("FAIL reset_idle_c21 got %0d want 0", c21); end
        tests_run++;
        if (c22 !== 32'sd0) begin tests_failed++; $display("FAIL reset_idle_c22 got %0d want 0", c22); end
    endtask

    task automatic test_basic_product();
        logic signed [31:0] o11, o12, o21, o22;
        feed_product(1'b0, o11, o12, o21, o22);
        tests_run++;
        if (o11 !== 75) begin tests_failed++; $display("FAIL basic_c11 got %0d want 75", o11); end
        tests_run++;
        if (o12 !== 7) begin tests_failed++; $display("FAIL basic_c12 got %0d want 7", o12); end
        tests_run++;
        if (o21 !== -38) begin tests_failed++; $display("FAIL basic_c21 got %0d want -38", o21); end
        tests_run++;
        if (o22 !== -4) begin tests_failed++; $display("FAIL basic_c22 got %0d want -4", o22); end
        // zeros streaming in must leave every accumulator untouched
        step(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        step(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (c11 !== 75) begin tests_failed++; $display("FAIL hold_c11 got %0d want 75", c11); end
        tests_run++;
        if (c12 !== 7) begin tests_failed++; $display("FAIL hold_c12 got %0d want 7", c12); end
        tests_run++;
        if (c21 !== -38) begin tests_failed++; $display("FAIL hold_c21 got %0d want -38", c21); end
        tests_run++;
        if (c22 !== -4) begin tests_failed++; $display("FAIL hold_c22 got %0d want -4", c22); end
    endtask

    task automatic test_extremes();
        // all -128, N=2, pushes aligned: each c = 2 * 16384 = 32768
        step(-128,    0, -128,    0, 1'b1, 1'b0, 1'b0);
        step(-128, -128, -128, -128, 1'b0, 1'b1, 1'b0);
        step(   0, -128,    0, -128, 1'b0, 1'b0, 1'b1);
        step(   0,    0,    0,    0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (c11 !== 32768) begin tests_failed++; $display("FAIL neg128_c11 got %0d want 32768", c11); end
        tests_run++;
        if (c12 !== 32768) begin tests_failed++; $display("FAIL neg128_c12 got %0d want 32768", c12); end
        tests_run++;
        if (c21 !== 32768) begin tests_failed++; $display("FAIL neg128_c21 got %0d want 32768", c21); end
        tests_run++;
        if (c22 !== 32768) begin tests_failed++; $display("FAIL neg128_c22 got %0d want 32768", c22); end
        // 127*127 = 16129 added per beat in PE11; other streams stay zero
        step(127, 0, 127, 0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (c11 !== 16129) begin tests_failed++; $display("FAIL pos127_beat1 got %0d want 16129", c11); end
        for (int i = 0; i < 9; i++) step(127, 0, 127, 0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (c11 !== 161290) begin tests_failed++; $display("FAIL pos127_beat10 got %0d want 161290", c11); end
        step(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        step(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (c11 !== 161290) begin tests_failed++; $display("FAIL pos127_hold got %0d want 161290", c11); end
        tests_run++;
        if (c12 !== 32768) begin tests_failed++; $display("FAIL pos127_c12_untouched got %0d want 32768", c12); end
        tests_run++;
        if (c21 !== 32768) begin tests_failed++; $display("FAIL pos127_c21_untouched got %0d want 32768", c21); end
        tests_run++;
        if (c22 !== 32768) begin tests_failed++; $display("FAIL pos127_c22_untouched got %0d want 32768", c22); end
    endtask

    task automatic test_back_to_back();
        logic signed [31:0] o11, o12, o21, o22;
        // accumulators hold old values; aligned pushes must discard them
        feed_product(1'b1, o11, o12, o21, o22);
        tests_run++;
        if (o11 !== 75) begin tests_failed++; $display("FAIL b2b_c11 got %0d want 75", o11); end
        tests_run++;
        if (o12 !== 7) begin tests_failed++; $display("FAIL b2b_c12 got %0d want 7", o12); end
        tests_run++;
        if (o21 !== -38) begin tests_failed++; $display("FAIL b2b_c21 got %0d want -38", o21); end
        tests_run++;
        if (o22 !== -4) begin tests_failed++; $display("FAIL b2b_c22 got %0d want -4", o22); end
        // immediately again, no bubble
        feed_product(1'b1, o11, o12, o21, o22);
        tests_run++;
        if (o11 !== 75) begin tests_failed++; $display("FAIL b2b2_c11 got %0d want 75", o11); end
        tests_run++;
        if (o22 !== -4) begin tests_failed++; $display("FAIL b2b2_c22 got %0d want -4", o22); end
    endtask

    task automatic test_async_reset_midstream();
        logic signed [31:0] o11, o12, o21, o22;
        step(-6, 0, -2, 0, 1'b1, 1'b0, 1'b0);
        step( 7, 1,  9, 0, 1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (c11 !== 32'sd0) begin tests_failed++; $display("FAIL midrst_c11 got %0d want 0", c11); end
        tests_run++;
        if (c12 !== 32'sd0) begin tests_failed++; $display("FAIL midrst_c12 got %0d want 0", c12); end
        tests_run++;
        if (c21 !== 32'sd0) begin tests_failed++; $display("FAIL midrst_c21 got %0d want 0", c21); end
        tests_run++;
        if (c22 !== 32'sd0) begin tests_failed++; $display("FAIL midrst_c22 got %0d want 0", c22); end
        // reset outranks data and push at the edge
        a1X = 8'sd5; bX1 = 8'sd5; push11 = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (c11 !== 32'sd0) begin tests_failed++; $display("FAIL midrst_priority_c11 got %0d want 0", c11); end
        reset = 1'b0;
        feed_product(1'b0, o11, o12, o21, o22);
        tests_run++;
        if (o11 !== 75) begin tests_failed++; $display("FAIL after_rst_c11 got %0d want 75", o11); end
        tests_run++;
        if (o12 !== 7) begin tests_failed++; $display("FAIL after_rst_c12 got %0d want 7", o12); end
        tests_run++;
        if (o21 !== -38) begin tests_failed++; $display("FAIL after_rst_c21 got %0d want -38", o21); end
        tests_run++;
        if (o22 !== -4) begin tests_failed++; $display("FAIL after_rst_c22 got %0d want -4", o22); end
    endtask

    task automatic test_push_zero();
        // state entering: 75, 7, -38, -4
        step(0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if (c11 !== 75) begin tests_failed++; $display("FAIL pzedge_c11 got %0d want 75", c11); end
        tests_run++;
        if (c12 !== 32'sd0) begin tests_failed++; $display("FAIL pzedge_c12 got %0d want 0", c12); end
        tests_run++;
        if (c21 !== 32'sd0) begin tests_failed++; $display("FAIL pzedge_c21 got %0d want 0", c21); end
        tests_run++;
        if (c22 !== -4) begin tests_failed++; $display("FAIL pzedge_c22 got %0d want -4", c22); end
        step(0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (c11 !== 32'sd0) begin tests_failed++; $display("FAIL pz11_c11 got %0d want 0", c11); end
        tests_run++;
        if (c22 !== -4) begin tests_failed++; $display("FAIL pz11_c22 got %0d want -4", c22); end
        step(0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (c22 !== 32'sd0) begin tests_failed++; $display("FAIL pz22_c22 got %0d want 0", c22); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic_product();
        test_extremes();
        test_back_to_back();
        test_async_reset_midstream();
        test_push_zero();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/systolic_matrix.md
# systolic_matrix

2×2 output-stationary systolic array computing a signed 8-bit matrix product C = A·B into four 32-bit accumulators. Row i of A streams in from the left on `aiX`; column j of B streams in from the top on `bXj`. Both skew by one cycle per row/column. Operands ripple right and down through registered processing elements (PEs). It is the compute core of the tensor-core datapath, and its outputs are read directly by the surrounding control logic.

## Interface
- No parameters. The array is fixed at 2×2 with 8-bit operands and 32-bit accumulators.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `push11` in 1: restart accumulation in PE11.
- `pushedge` in 1: restart accumulation in PE12 and PE21 (the anti-diagonal).
- `push22` in 1: restart accumulation in PE22.
- `a1X` in 8, signed: row-1 A operand stream into PE11.
- `a2X` in 8, signed: row-2 A operand stream into PE21.
- `bX1` in 8, signed: column-1 B operand stream into PE11.
- `bX2` in 8, signed: column-2 B operand stream into PE12.
- `c11`, `c12`, `c21`, `c22` out 32, signed: PE accumulator values, driven directly by the registers.

## Operation
- Each PE has an A input, a B input, registered pass-through A (to the right) and B (downward), and a 32-bit accumulator.
- Wiring:
  - PE11 takes A from `a1X` and B from `bX1`.
  - PE12 takes A from PE11's A register and B from `bX2`.
  - PE21 takes A from `a2X` and B from PE11's B register.
  - PE22 takes A from PE21's A register and B from PE12's B register.
- Every rising edge, each PE performs:
  - A pass-through register <= A input.
  - B pass-through register <= B input.
  - Accumulator <= accumulator + A·B, or <= A·B when that PE's push is high.
- Arithmetic:
  - A·B is a signed 8×8 product into 16 bits, sign-extended to 32.
  - Accumulation wraps modulo 2^32; there is no saturation and no overflow flag.
- Push asserted:
  - The accumulator loads the current product, so a new matrix can follow with no bubble cycle.
  - Push does not affect the pass-through registers.
  - Push asserted while the operands are 0 clears the accumulator.
- Caller input schedule for an N-deep product (N = 2):
  - `a1X`/`bX1` carry k = 0..N-1 on cycles t0..t0+N-1.
  - `a2X`/`bX2` carry the same streams delayed by one cycle.
  - Every idle slot is driven with 0.

## Timing
- Reset (async assert) sets every accumulator and every pass-through register to 0, so all `c` outputs read 0. Reset release takes effect at the next edge.
- Reset has priority over push and data. Reset asserted mid-computation discards all partial sums.
- Inputs are sampled on the rising edge. Outputs change only after a clock edge.
- Final-value latency, with first data sampled at edge E0 and N = 2:

| Output | Final after edge |
|---|---|
| `c11` | E0+1 |
| `c12`, `c21` | E0+2 |
| `c22` | E0+3 |

- In general, `cij` is final at edge E0 + N-1 + (i-1) + (j-1).
- Accumulators hold their value while zeros stream in.
- Push for a back-to-back matrix must be aligned to that PE's first new operand edge:
  - `push11` at E0'.
  - `pushedge` at E0'+1.
  - `push22` at E0'+2.
- Simultaneous pushes on different PEs are independent.

## Test plan
- Reset, then idle zero inputs → all `c` outputs = 0, including immediately on async assertion with no clock edge.
- Basic product, with A=[[-6,7],[1,-4]] and B=[[-2,0],[9,1]]. Skewed stimulus per cycle from E0 (`a1X`, `a2X`, `bX1`, `bX2`): (-6,0,-2,0), (7,1,9,0), (0,-4,0,1), (0,0,0,0). Expected outputs:
  - `c11`=75 after E0+1.
  - `c12`=7 and `c21`=-38 after E0+2.
  - `c22`=-4 after E0+3.
- Extremes: all operands -128 with N=2 → every `c` = 32768. Then stream 127×127 repeatedly → the accumulator increments by 16129 per beat and wraps modulo 2^32 with no saturation.
- Back-to-back: feed the previous product again with pushes aligned (`push11` E0', `pushedge` E0'+1, `push22` E0'+2) → outputs equal the new product (75, 7, -38, -4), not the sums.
- Async reset asserted mid-stream between edges → all `c` outputs are 0 at once. Restarting stimulus afterwards yields the correct product.
- Push with zero operands → only the targeted PE(s) clear to 0; the other accumulators are unchanged.
